// File: rtl/watch_pkg.sv
// Shared definitions for the watch datapath and its UART reporter.
//   - ASCII constants for frame formatting
//   - reporter state encoding
//   - frame length constants and frame index width
//   - time snapshot struct
package watch_pkg;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_DOT   = 8'h2E;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  localparam int FRAME_LEN_CRLF = 13;
  localparam int FRAME_LEN_LF   = 12;
  localparam int IDX_W          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } rep_state_e;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] csec;
  } time_snap_t;
endpackage

// File: rtl/bin2ascii2.sv
// Two-digit decimal ASCII formatter.
//   val      : binary value 0-127
//   tens_asc : ASCII tens digit
//   ones_asc : ASCII ones digit
// Values above 99 saturate to "99".
module bin2ascii2
  import watch_pkg::*;
(
  input  logic [6:0] val,
  output logic [7:0] tens_asc,
  output logic [7:0] ones_asc
);
  logic [6:0] sat;
  logic [3:0] tens;
  logic [3:0] ones;

  always_comb begin
    sat      = (val > 7'd99) ? 7'd99 : val;
    tens     = 4'(sat / 7'd10);
    ones     = 4'(sat % 7'd10);
    tens_asc = ASC_0 | {4'd0, tens};
    ones_asc = ASC_0 | {4'd0, ones};
  end
endmodule

// File: rtl/uart_time_reporter.sv
// Formats the watch time as "HH:MM:SS.CC" + line end and pushes it one byte
// per cycle into the UART TX FIFO, honouring the FIFO full flag.
//   clk, reset  : clock, asynchronous active-high reset
//   report_req  : one-cycle frame request
//   hour/min/sec/csec : live watch time (binary)
//   tx_full     : TX FIFO full, stalls the frame
//   tx_data     : byte to write (frame[index] during SEND, else 0x00)
//   wr_en       : FIFO write strobe
//   busy        : frame in progress or a request pending
// Parameter EOL_CRLF: 1 -> CR LF line end (13 bytes), 0 -> LF only (12).
// Macro REPORT_PERIODIC_EN: a change of sec also requests a frame.
module uart_time_reporter
  import watch_pkg::*;
#(
  parameter int EOL_CRLF = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       report_req,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [6:0] csec,
  input  logic       tx_full,
  output logic [7:0] tx_data,
  output logic       wr_en,
  output logic       busy
);
  localparam int              LEN      = (EOL_CRLF != 0) ? FRAME_LEN_CRLF : FRAME_LEN_LF;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  rep_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d;
  time_snap_t       snap_q, snap_d;
  time_snap_t       cur;
  logic             req;
  logic [7:0]       frame_byte;
  logic [7:0]       h_t, h_o, m_t, m_o, s_t, s_o, c_t, c_o;

  assign cur = {hour, min, sec, csec};

`ifdef REPORT_PERIODIC_EN
  // A seconds rollover acts like an external request.
  logic [5:0] sec_prev_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sec_prev_q <= '0;
    else       sec_prev_q <= sec;
  end
  assign req = report_req | (sec != sec_prev_q);
`else
  assign req = report_req;
`endif

  bin2ascii2 u_hour (.val({2'b00, snap_q.hour}), .tens_asc(h_t), .ones_asc(h_o));
  bin2ascii2 u_min  (.val({1'b0,  snap_q.min}),  .tens_asc(m_t), .ones_asc(m_o));
  bin2ascii2 u_sec  (.val({1'b0,  snap_q.sec}),  .tens_asc(s_t), .ones_asc(s_o));
  bin2ascii2 u_csec (.val(snap_q.csec),          .tens_asc(c_t), .ones_asc(c_o));

  always_comb begin
    frame_byte = 8'h00;
    case (idx_q)
      4'd0:  frame_byte = h_t;
      4'd1:  frame_byte = h_o;
      4'd2:  frame_byte = ASC_COLON;
      4'd3:  frame_byte = m_t;
      4'd4:  frame_byte = m_o;
      4'd5:  frame_byte = ASC_COLON;
      4'd6:  frame_byte = s_t;
      4'd7:  frame_byte = s_o;
      4'd8:  frame_byte = ASC_DOT;
      4'd9:  frame_byte = c_t;
      4'd10: frame_byte = c_o;
      4'd11: frame_byte = (EOL_CRLF != 0) ? ASC_CR : ASC_LF;
      4'd12: frame_byte = ASC_LF;
      default: frame_byte = 8'h00;
    endcase
  end

  assign wr_en   = (state_q == SEND) && !tx_full;
  assign tx_data = (state_q == SEND) ? frame_byte : 8'h00;
  assign busy    = (state_q != IDLE) || pending_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    snap_d    = snap_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          snap_d  = cur;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // Requests arriving mid-frame collapse into one follow-up frame.
        if (req) pending_d = 1'b1;
        if (wr_en) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
        // A request landing in this cycle joins the immediate restart.
        if (pending_q || req) begin
          pending_d = 1'b0;
          snap_d    = cur;
          idx_d     = '0;
          state_d   = SEND;
        end else begin
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      snap_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      snap_q    <= snap_d;
    end
  end
endmodule

// File: tb/tb_uart_time_reporter.sv
// Randomized, self-checking bench for uart_time_reporter. Two instances share
// stimulus: u0 with CR LF line end, u1 with LF only. A frame-level reference
// model predicts the written byte stream, wr_en and busy every cycle.
module tb_uart_time_reporter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       report_req = 1'b0;
  logic [4:0] hour = '0;
  logic [5:0] min = '0;
  logic [5:0] sec = '0;
  logic [6:0] csec = '0;
  logic       tx_full = 1'b0;
  logic [1:0] wr_w;
  logic [1:0] busy_w;
  logic [7:0] td_w [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_time_reporter #(.EOL_CRLF(1)) u0 (
    .clk(clk), .reset(reset), .report_req(report_req), .hour(hour), .min(min),
    .sec(sec), .csec(csec), .tx_full(tx_full), .tx_data(td_w[0]),
    .wr_en(wr_w[0]), .busy(busy_w[0]));

  uart_time_reporter #(.EOL_CRLF(0)) u1 (
    .clk(clk), .reset(reset), .report_req(report_req), .hour(hour), .min(min),
    .sec(sec), .csec(csec), .tx_full(tx_full), .tx_data(td_w[1]),
    .wr_en(wr_w[1]), .busy(busy_w[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame text straight from the format rules: two saturated decimal digits
  // per field, separators, then the line end.
  function automatic logic [12:0][7:0] build_frame(input int h, input int m, input int s,
                                                   input int c, input bit crlf);
    logic [12:0][7:0] f;
    int v[4];
    int x;
    f = '0;
    v[0] = h; v[1] = m; v[2] = s; v[3] = c;
    for (int k = 0; k < 4; k++) begin
      x = (v[k] > 99) ? 99 : v[k];
      f[3*k]   = 8'(48 + x / 10);
      f[3*k+1] = 8'(48 + x % 10);
      if (k < 3) f[3*k+2] = (k == 2) ? 8'h2E : 8'h3A;
    end
    f[11] = crlf ? 8'h0D : 8'h0A;
    f[12] = crlf ? 8'h0A : 8'h00;
    return f;
  endfunction

  // Reference model: bytes left in the current frame, a one-cycle gap after
  // each frame, and a single pending flag.
  int               rem [2];
  int               bi [2];
  bit               gap [2];
  bit               pend [2];
  logic [12:0][7:0] frm [2];
  logic [5:0]       sec_prev_m;

  always @(posedge clk or posedge reset) begin
    bit rq;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        rem[i] <= 0; bi[i] <= 0; gap[i] <= 1'b0; pend[i] <= 1'b0; frm[i] <= '0;
      end
      sec_prev_m <= '0;
    end else begin
      rq = report_req;
`ifdef REPORT_PERIODIC_EN
      rq = rq | (sec != sec_prev_m);
`endif
      sec_prev_m <= sec;
      for (int i = 0; i < 2; i++) begin
        if (rem[i] > 0) begin
          if (rq) pend[i] <= 1'b1;
          if (!tx_full) begin
            bi[i]  <= bi[i] + 1;
            rem[i] <= rem[i] - 1;
            if (rem[i] == 1) gap[i] <= 1'b1;
          end
        end else if (gap[i]) begin
          gap[i] <= 1'b0;
          if (pend[i] || rq) begin
            frm[i] <= build_frame(int'(hour), int'(min), int'(sec), int'(csec), i == 0);
            bi[i]  <= 0;
            rem[i] <= (i == 0) ? 13 : 12;
          end
          pend[i] <= 1'b0;
        end else if (rq) begin
          frm[i] <= build_frame(int'(hour), int'(min), int'(sec), int'(csec), i == 0);
          bi[i]  <= 0;
          rem[i] <= (i == 0) ? 13 : 12;
        end
      end
    end
  end

  byte log0[$];
  byte log1[$];

  always @(negedge clk) begin
    logic       ew;
    logic       eb;
    logic [7:0] ed;
    for (int i = 0; i < 2; i++) begin
      ew = (rem[i] > 0) && !tx_full;
      eb = (rem[i] > 0) || gap[i] || pend[i];
      ed = (rem[i] > 0) ? frm[i][bi[i]] : 8'h00;
      chk((i == 0) ? "wr_en_u0" : "wr_en_u1", 32'(wr_w[i]), 32'(ew));
      chk((i == 0) ? "busy_u0" : "busy_u1", 32'(busy_w[i]), 32'(eb));
      chk((i == 0) ? "tx_data_u0" : "tx_data_u1", 32'(td_w[i]), 32'(ed));
    end
    if (wr_w[0]) log0.push_back(td_w[0]);
    if (wr_w[1]) log1.push_back(td_w[1]);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse();
    report_req = 1'b1;
    tick(1);
    report_req = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while ((busy_w != 2'b00) && k < bound) begin tick(1); k++; end
    if (busy_w != 2'b00) chk("wait_idle_timeout", 32'(busy_w), 32'd0);
  endtask

  task automatic wait_writes0(input int n, input int bound);
    int k = 0;
    while (log0.size() < n && k < bound) begin tick(1); k++; end
    if (log0.size() < n) chk("wait_writes_timeout", 32'(log0.size()), 32'(n));
  endtask

  task automatic chk_log0(input string nm, input string s, input bit crlf);
    byte exp[$];
    for (int k = 0; k < s.len(); k++) exp.push_back(s[k]);
    if (crlf) exp.push_back(8'h0D);
    exp.push_back(8'h0A);
    chk({nm, "_len"}, 32'(log0.size()), 32'(exp.size()));
    if (log0.size() >= exp.size())
      for (int k = 0; k < exp.size(); k++) chk(nm, 32'(log0[k]), 32'(exp[k]));
  endtask

  initial begin
    logic [12:0][7:0] f;
    string            s;

    // Pin the model's formatter to hand-written text.
    f = build_frame(13, 5, 9, 42, 1'b1);
    s = "13:05:09.42";
    for (int k = 0; k < 11; k++) chk("model_frame_basic", 32'(f[k]), 32'(s[k]));
    chk("model_frame_cr", 32'(f[11]), 32'h0D);
    f = build_frame(0, 7, 3, 120, 1'b0);
    chk("model_sat_tens", 32'(f[9]), 32'h39);
    chk("model_lf_end", 32'(f[11]), 32'h0A);

    tick(3);
    chk("reset_wr_en", 32'(wr_w), 32'd0);
    chk("reset_busy", 32'(busy_w), 32'd0);
    chk("reset_tx_data", 32'(td_w[0]), 32'd0);
    reset = 1'b0;
    tick(2);

    // Basic frame.
    hour = 5'd13; min = 6'd5; sec = 6'd9; csec = 7'd42;
    wait_idle(50);
    log0.delete();
    pulse();
    wait_idle(50);
    chk_log0("basic_frame", "13:05:09.42", 1'b1);

    // Backpressure from byte 3.
    log0.delete();
    pulse();
    wait_writes0(3, 50);
    tx_full = 1'b1;
    tick(5);
    tx_full = 1'b0;
    wait_idle(50);
    chk_log0("backpressure_frame", "13:05:09.42", 1'b1);

    // Snapshot held while the live seconds move.
    log0.delete();
    pulse();
    tick(4);
    sec = 6'd10;
    wait_idle(80);
    if (log0.size() >= 8) chk("snapshot_sec_ones", 32'(log0[7]), 32'h39);
    else chk("snapshot_len", 32'(log0.size()), 32'd13);

    // Three extra requests during one frame merge into one follow-up.
    log0.delete();
    pulse();
    tick(2); pulse();
    tick(2); pulse();
    min = 6'd6;
    tick(2); pulse();
    wait_idle(100);
`ifndef REPORT_PERIODIC_EN
    chk("pending_merge_bytes", 32'(log0.size()), 32'd26);
    if (log0.size() >= 26) chk("pending_second_min", 32'(log0[13+4]), 32'h36);
`endif

    // Saturation on the LF-only instance.
    hour = 5'd0; min = 6'd7; csec = 7'd120;
    wait_idle(50);
    log1.delete();
    pulse();
    wait_idle(50);
    chk("sat_len", 32'(log1.size() >= 12), 32'd1);
    if (log1.size() >= 12) begin
      s = "00:07:10.99";
      for (int k = 0; k < 11; k++) chk("sat_frame", 32'(log1[k]), 32'(s[k]));
      chk("sat_lf", 32'(log1[11]), 32'h0A);
    end

    // Reset mid-frame.
    log0.delete();
    pulse();
    wait_writes0(6, 50);
    reset = 1'b1;
    #1;
    chk("midreset_wr_en", 32'(wr_w), 32'd0);
    chk("midreset_busy", 32'(busy_w), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);
    wait_idle(50);
    log0.delete();
    pulse();
    wait_idle(50);
    chk_log0("after_reset_frame", "00:07:10.99", 1'b1);

`ifdef REPORT_PERIODIC_EN
    // One frame per seconds step.
    sec = 6'd0;
    tick(2);
    wait_idle(50);
    log0.delete();
    sec = 6'd1;
    tick(20);
    sec = 6'd2;
    tick(2);
    wait_idle(50);
    chk("periodic_bytes", 32'(log0.size()), 32'd26);
`endif

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      report_req = ($urandom_range(0, 5) == 0);
      tx_full    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        hour = 5'($urandom_range(0, 23));
        min  = 6'($urandom_range(0, 59));
        csec = 7'($urandom_range(0, 127));
      end
      if ($urandom_range(0, 49) == 0) sec = 6'($urandom_range(0, 59));
      if ($urandom_range(0, 199) == 0) reset = 1'b1;
      else reset = 1'b0;
      tick(1);
    end
    report_req = 1'b0;
    tx_full = 1'b0;
    reset = 1'b0;
    tick(2);
    wait_idle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
